// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus controller: access-size codes,
// address classes, controller states and byte-lane steering helpers.
package dmem_pkg;

    // SIZE encodings driven by the core; any size with bit 1 set is a byte access.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        CLS_SRAM   = 2'd0,
        CLS_STDOUT = 2'd1,
        CLS_EXIT   = 2'd2,
        CLS_ERR    = 2'd3
    } addr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Byte-lane write enables. Misaligned halves and words are aligned down.
    function automatic logic [3:0] we_gen(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] we;
        if (size[1]) begin
            we = 4'b0001 << lane;
        end else if (size == SZ_HALF) begin
            we = lane[1] ? 4'b1100 : 4'b0011;
        end else begin
            we = 4'b1111;
        end
        return we;
    endfunction

    // Replicate the right-aligned store data so every candidate lane carries it;
    // the write enables then pick the lane(s) actually written.
    function automatic logic [31:0] wdata_steer(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] s;
        if (size[1]) begin
            s = {4{d[7:0]}};
        end else if (size == SZ_HALF) begin
            s = {2{d[15:0]}};
        end else begin
            s = d;
        end
        return s;
    endfunction

    // Shift the addressed lane(s) down to bit 0 and zero-extend.
    function automatic logic [31:0] rdata_extract(input logic [1:0] size, input logic [1:0] lane,
                                                  input logic [31:0] d);
        logic [31:0] sh;
        logic [31:0] r;
        sh = d >> {lane, 3'b000};
        if (size[1]) begin
            r = {24'h0, sh[7:0]};
        end else if (size == SZ_HALF) begin
            r = lane[1] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/stdout_fifo.sv
// Show-ahead synchronous FIFO buffering STDOUT characters toward the host.
// Pointers carry one extra wrap bit to tell full from empty.
module stdout_fifo
    import dmem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    // Character storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer advance; reset flushes the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: accepts core requests, drives a word-wide
// synchronous SRAM with lane steering, decodes STDOUT/EXIT MMIO and answers
// with a one-cycle active-low ACKD_n after a programmable latency.
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] DMEM_START   = 32'h0800_0000,
    parameter int          DMEM_AW      = 20,
    parameter int          DMEM_LATENCY = 1,
    parameter logic [31:0] STDOUT_ADDR  = 32'hf000_0000,
    parameter logic [31:0] EXIT_ADDR    = 32'hff00_0000,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        DAD,
    input  logic               MREQ,
    input  logic               WRITE,
    input  logic [1:0]         SIZE,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ACKD_n,
    output logic               sram_en,
    output logic [3:0]         sram_we,
    output logic [DMEM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic               stdout_valid,
    output logic [7:0]         stdout_data,
    input  logic               stdout_ready,
    output logic               exit_o,
    output logic [31:0]        exit_code,
    output logic               bus_err
);

    state_e      state_reg, state_next;
    logic [3:0]  cnt_reg;
    addr_class_e cls_reg;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic [1:0]  lane_reg;
    logic [7:0]  char_reg;
    logic        rd_pend_reg;
    logic [31:0] rdata_reg;
    logic        exit_reg;
    logic [31:0] exit_code_reg;
    logic        bus_err_reg;

    addr_class_e cls_live;
    logic [30:0] win_off;
    logic        accept;
    logic        live_push;
    logic        held_push;
    logic        fifo_space;
    logic        cnt_done;
    logic        go_ack;
    logic        fifo_push;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        fifo_empty;

    // Word offset into the SRAM window; a borrow lands in the upper bits,
    // so addresses below the window decode as out-of-range too.
    assign win_off = {1'b0, DAD[31:2]} - {1'b0, DMEM_START[31:2]};

    // Classify the address presented on DAD.
    always_comb begin
        cls_live = CLS_ERR;
        if (DAD == STDOUT_ADDR) begin
            cls_live = CLS_STDOUT;
        end else if (DAD == EXIT_ADDR) begin
            cls_live = CLS_EXIT;
        end else if (win_off[30:DMEM_AW] == '0) begin
            cls_live = CLS_SRAM;
        end
    end

    assign accept     = (state_reg == ST_IDLE) && MREQ;
    assign live_push  = WRITE && SIZE[1] && (cls_live == CLS_STDOUT);
    assign held_push  = write_reg && size_reg[1] && (cls_reg == CLS_STDOUT);
    assign fifo_space = !fifo_full || stdout_ready;
    assign cnt_done   = (cnt_reg <= 4'd1);

    // SRAM port is driven only during the accept cycle so the read data is
    // available in the first cycle after the accept edge.
    always_comb begin
        sram_en    = accept && !rst && (cls_live == CLS_SRAM);
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        if (sram_en) begin
            sram_addr = win_off[DMEM_AW-1:0];
            if (WRITE) begin
                sram_we    = we_gen(SIZE, DAD[1:0]);
                sram_wdata = wdata_steer(SIZE, wdata);
            end
        end
    end

    // Next-state logic; a STDOUT byte store may only complete when the FIFO has room.
    always_comb begin
        state_next = state_reg;
        go_ack     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (MREQ) begin
                    if (DMEM_LATENCY == 1 && (!live_push || fifo_space)) begin
                        state_next = ST_ACK;
                        go_ack     = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_done && (!held_push || fifo_space)) begin
                    state_next = ST_ACK;
                    go_ack     = 1'b1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The character enters the FIFO on the same edge that moves the FSM into ACK.
    assign fifo_push = go_ack && ((state_reg == ST_IDLE) ? live_push : held_push);
    assign fifo_din  = (state_reg == ST_IDLE) ? wdata[7:0] : char_reg;

    // Request capture, latency countdown, load-data capture and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            cls_reg       <= CLS_SRAM;
            write_reg     <= 1'b0;
            size_reg      <= SZ_WORD;
            lane_reg      <= 2'b00;
            char_reg      <= 8'h00;
            rd_pend_reg   <= 1'b0;
            rdata_reg     <= 32'h0;
            exit_reg      <= 1'b0;
            exit_code_reg <= 32'h0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_pend_reg <= 1'b0;
            if (rd_pend_reg) begin
                rdata_reg <= rdata_extract(size_reg, lane_reg, sram_rdata);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (MREQ) begin
                        cls_reg     <= cls_live;
                        write_reg   <= WRITE;
                        size_reg    <= SIZE;
                        lane_reg    <= DAD[1:0];
                        char_reg    <= wdata[7:0];
                        cnt_reg     <= 4'(DMEM_LATENCY - 1);
                        rd_pend_reg <= !WRITE && (cls_live == CLS_SRAM);
                        // MMIO and out-of-window loads read as zero.
                        if (!WRITE && cls_live != CLS_SRAM) begin
                            rdata_reg <= 32'h0;
                        end
                        if (WRITE && cls_live == CLS_EXIT && !exit_reg) begin
                            exit_reg      <= 1'b1;
                            exit_code_reg <= wdata;
                        end
                        if (cls_live == CLS_ERR) begin
                            bus_err_reg <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load data is forwarded straight from the SRAM in the capture cycle so a
    // one-cycle latency still presents valid data with the ack.
    assign rdata     = rd_pend_reg ? rdata_extract(size_reg, lane_reg, sram_rdata) : rdata_reg;
    assign ACKD_n    = (state_reg != ST_ACK);
    assign exit_o    = exit_reg;
    assign exit_code = exit_code_reg;
    assign bus_err   = bus_err_reg;
    assign stdout_valid = !fifo_empty;

    stdout_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (stdout_ready),
        .pop_data  (stdout_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: one instance at latency 1, one at latency 3,
// each with a small behavioural SRAM.
module tb_dmem_bus_ctrl;

    localparam logic [1:0]  SZW = 2'b00;
    localparam logic [1:0]  SZH = 2'b01;
    localparam logic [1:0]  SZB = 2'b10;
    localparam logic [31:0] STDOUT = 32'hf000_0000;
    localparam logic [31:0] EXITA  = 32'hff00_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, mreq_a, mreq_b, ready_a, ready_b;
    logic [31:0] dad, wdata;
    logic        write;
    logic [1:0]  size;
    logic        sel;

    logic [31:0] rdata_a, rdata_b, swd_a, swd_b, srd_a, srd_b, code_a, code_b;
    logic        ack_a, ack_b, en_a, en_b, sv_a, sv_b, exit_a, exit_b, err_a, err_b;
    logic [3:0]  we_a, we_b;
    logic [19:0] addr_a, addr_b;
    logic [7:0]  sd_a, sd_b;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_en;
    logic [3:0]  s_we;
    logic [19:0] s_addr;
    logic [31:0] s_wd, s_rd;
    int          lat, lows;

    dmem_bus_ctrl u_dut_a (
        .clk(clk), .rst(rst_a), .DAD(dad), .MREQ(mreq_a), .WRITE(write), .SIZE(size),
        .wdata(wdata), .rdata(rdata_a), .ACKD_n(ack_a), .sram_en(en_a), .sram_we(we_a),
        .sram_addr(addr_a), .sram_wdata(swd_a), .sram_rdata(srd_a), .stdout_valid(sv_a),
        .stdout_data(sd_a), .stdout_ready(ready_a), .exit_o(exit_a), .exit_code(code_a),
        .bus_err(err_a)
    );

    dmem_bus_ctrl #(.DMEM_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst_b), .DAD(dad), .MREQ(mreq_b), .WRITE(write), .SIZE(size),
        .wdata(wdata), .rdata(rdata_b), .ACKD_n(ack_b), .sram_en(en_b), .sram_we(we_b),
        .sram_addr(addr_b), .sram_wdata(swd_b), .sram_rdata(srd_b), .stdout_valid(sv_b),
        .stdout_data(sd_b), .stdout_ready(ready_b), .exit_o(exit_b), .exit_code(code_b),
        .bus_err(err_b)
    );

    // Behavioural SRAMs: byte-lane writes, registered read (read-before-write).
    always @(posedge clk) begin
        if (en_a) begin
            srd_a <= mem_a[addr_a[7:0]];
            for (int k = 0; k < 4; k++)
                if (we_a[k]) mem_a[addr_a[7:0]][8*k +: 8] <= swd_a[8*k +: 8];
        end
        if (en_b) begin
            srd_b <= mem_b[addr_b[7:0]];
            for (int k = 0; k < 4; k++)
                if (we_b[k]) mem_b[addr_b[7:0]][8*k +: 8] <= swd_b[8*k +: 8];
        end
    end

    wire        m_ack   = sel ? ack_b   : ack_a;
    wire [31:0] m_rdata = sel ? rdata_b : rdata_a;
    wire        m_en    = sel ? en_b    : en_a;
    wire [3:0]  m_we    = sel ? we_b    : we_a;
    wire [19:0] m_addr  = sel ? addr_b  : addr_a;
    wire [31:0] m_swd   = sel ? swd_b   : swd_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and sample the SRAM port during the accept cycle.
    task automatic start_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d);
        @(negedge clk);
        write = w; size = sz; dad = a; wdata = d;
        if (sel) mreq_b = 1'b1; else mreq_a = 1'b1;
        #1;
        s_en = m_en; s_we = m_we; s_addr = m_addr; s_wd = m_swd;
        @(posedge clk);
    endtask

    // Wait up to max cycles for ACKD_n low; lat=0 means no ack seen.
    task automatic wait_ack(input int max);
        bit got = 1'b0;
        lat = 0;
        for (int n = 1; n <= max && !got; n++) begin
            @(negedge clk);
            if (!m_ack) begin
                got = 1'b1; lat = n; s_rd = m_rdata;
                mreq_a = 1'b0; mreq_b = 1'b0;
            end
        end
    endtask

    task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d);
        start_req(w, sz, a, d);
        wait_ack(20);
        if (lat == 0) begin
            mreq_a = 1'b0; mreq_b = 1'b0;
        end
        @(negedge clk);
        check("ack_one_cycle", {31'h0, m_ack}, 32'h1);
        $display("[TB] dut%0d %s size=%0d addr=%h wdata=%h lat=%0d rdata=%h",
                 sel ? 3 : 1, w ? "ST" : "LD", sz, a, d, lat, s_rd);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; mreq_a = 1'b0; mreq_b = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0; sel = 1'b0;
        dad = 32'h0; wdata = 32'h0; write = 1'b0; size = SZW; s_rd = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ackd_n",  {31'h0, ack_a}, 32'h1);
        check("rst_rdata",   rdata_a, 32'h0);
        check("rst_sram_en", {31'h0, en_a}, 32'h0);
        check("rst_stdout_valid", {31'h0, sv_a}, 32'h0);
        check("rst_exit",    {31'h0, exit_a}, 32'h0);
        check("rst_bus_err", {31'h0, err_a}, 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;

        // 1: word store then load at latency 1
        access(1'b1, SZW, 32'h0800_0010, 32'hDEAD_BEEF);
        check("t1_st_en",   {31'h0, s_en}, 32'h1);
        check("t1_st_we",   {28'h0, s_we}, 32'hF);
        check("t1_st_addr", {12'h0, s_addr}, 32'h4);
        check("t1_st_wd",   s_wd, 32'hDEAD_BEEF);
        check("t1_st_lat",  lat, 1);
        access(1'b0, SZW, 32'h0800_0010, 32'h0);
        check("t1_ld_we",   {28'h0, s_we}, 32'h0);
        check("t1_ld_lat",  lat, 1);
        check("t1_ld_data", s_rd, 32'hDEAD_BEEF);
        check("t1_ld_hold", rdata_a, 32'hDEAD_BEEF);

        // 2: upper-half store, then word / byte / half loads
        access(1'b1, SZH, 32'h0800_0012, 32'h0000_1234);
        check("t2_st_we",   {28'h0, s_we}, 32'hC);
        check("t2_st_hi",   {16'h0, s_wd[31:16]}, 32'h1234);
        check("t2_st_addr", {12'h0, s_addr}, 32'h4);
        access(1'b0, SZW, 32'h0800_0010, 32'h0);
        check("t2_ld_word", s_rd, 32'h1234_BEEF);
        access(1'b0, SZB, 32'h0800_0013, 32'h0);
        check("t2_ld_byte", s_rd, 32'h0000_0012);
        access(1'b0, SZH, 32'h0800_0012, 32'h0);
        check("t2_ld_half", s_rd, 32'h0000_1234);
        access(1'b1, SZB, 32'h0800_0011, 32'h0000_00A5);
        check("t2_byte_we", {28'h0, s_we}, 32'h2);
        check("t2_byte_wd", s_wd, 32'hA5A5_A5A5);
        access(1'b0, SZB, STDOUT, 32'h0);
        check("mmio_ld_zero", s_rd, 32'h0);

        // 3: fill the STDOUT FIFO, ninth store stalls until a pop
        for (int i = 0; i < 8; i++) begin
            access(1'b1, SZB, STDOUT, 32'h41 + i);
            check("t3_lat", lat, 1);
        end
        check("t3_sram_en", {31'h0, s_en}, 32'h0);
        check("t3_valid",   {31'h0, sv_a}, 32'h1);
        start_req(1'b1, SZB, STDOUT, 32'h49);
        wait_ack(6);
        check("t3_ninth_stall", lat, 0);
        check("t3_ninth_ackd_n", {31'h0, ack_a}, 32'h1);
        ready_a = 1'b1;
        check("t3_first_pop", {24'h0, sd_a}, 32'h41);
        @(negedge clk);
        ready_a = 1'b0;
        check("t3_ninth_ack", {31'h0, ack_a}, 32'h0);
        mreq_a = 1'b0;
        @(negedge clk);
        check("t3_ninth_ack_one", {31'h0, ack_a}, 32'h1);
        $display("[TB] dut1 ST stdout ninth char released by pop");
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("t3_pop_order", {24'h0, sd_a}, 32'h41 + i);
            ready_a = 1'b1;
        end
        @(negedge clk);
        ready_a = 1'b0;
        check("t3_drained", {31'h0, sv_a}, 32'h0);

        // 4: first exit store wins
        access(1'b1, SZW, EXITA, 32'h0000_002A);
        check("t4_exit",      {31'h0, exit_a}, 32'h1);
        check("t4_code",      code_a, 32'h2A);
        access(1'b1, SZW, EXITA, 32'h0000_0001);
        check("t4_exit_held", {31'h0, exit_a}, 32'h1);
        check("t4_code_held", code_a, 32'h2A);
        check("t4_acked",     lat, 1);

        // 6: out-of-window load
        check("t6_err_before", {31'h0, err_a}, 32'h0);
        access(1'b0, SZW, 32'h0000_0100, 32'h0);
        check("t6_sram_en", {31'h0, s_en}, 32'h0);
        check("t6_lat",     lat, 1);
        check("t6_rdata",   s_rd, 32'h0);
        check("t6_bus_err", {31'h0, err_a}, 32'h1);
        access(1'b0, SZW, 32'h0800_0010, 32'h0);
        check("t6_good_ld", s_rd, 32'h1234_A5EF);
        check("t6_err_sticky", {31'h0, err_a}, 32'h1);

        // 5: latency 3, reset during an access
        sel = 1'b1;
        access(1'b1, SZW, 32'h0800_0020, 32'hCAFE_F00D);
        check("t5_st_lat", lat, 3);
        check("t5_st_addr", {12'h0, s_addr}, 32'h8);
        access(1'b1, SZB, STDOUT, 32'h5A);
        check("t5_push_lat", lat, 3);
        check("t5_push_valid", {31'h0, sv_b}, 32'h1);
        start_req(1'b0, SZW, 32'h0800_0020, 32'h0);
        @(negedge clk);
        rst_b = 1'b1; mreq_b = 1'b0;
        #1;
        check("t5_rst_ackd_n", {31'h0, ack_b}, 32'h1);
        check("t5_rst_rdata",  rdata_b, 32'h0);
        check("t5_rst_en",     {31'h0, en_b}, 32'h0);
        check("t5_rst_we",     {28'h0, we_b}, 32'h0);
        check("t5_rst_addr",   {12'h0, addr_b}, 32'h0);
        check("t5_rst_wdata",  swd_b, 32'h0);
        check("t5_rst_flush",  {31'h0, sv_b}, 32'h0);
        check("t5_rst_exit",   {31'h0, exit_b}, 32'h0);
        check("t5_rst_code",   code_b, 32'h0);
        check("t5_rst_err",    {31'h0, err_b}, 32'h0);
        @(negedge clk);
        rst_b = 1'b0;
        lows = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (!ack_b) lows++;
        end
        check("t5_no_ack_pulse", lows, 0);
        $display("[TB] dut3 LD aborted by reset");
        access(1'b0, SZW, 32'h0800_0020, 32'h0);
        check("t5_post_lat",  lat, 3);
        check("t5_post_data", s_rd, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
